// File: rtl/sha_resp_pkg.sv
// Shared types and constants for the SHA-256 memory responder.
package sha_resp_pkg;

   localparam int HASH_WORDS = 8;
   localparam int WORD_W     = 32;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_START,
      ST_WAIT_LO,
      ST_WAIT_HI,
      ST_DRAIN_RD,
      ST_DRAIN_PRES
   } resp_state_e;

endpackage

// File: rtl/sha_resp_ram.sv
// DEPTH x 32 word RAM: one write port, two registered read ports (core and drain).
module sha_resp_ram
   import sha_resp_pkg::*;
#(
   parameter int DEPTH  = 64,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WORD_W-1:0] wdata,
   input  logic [ADDR_W-1:0] core_raddr,
   output logic [WORD_W-1:0] core_rdata,
   input  logic              drain_re,
   input  logic [ADDR_W-1:0] drain_raddr,
   output logic [WORD_W-1:0] drain_rdata
);

   logic [WORD_W-1:0] mem [DEPTH];

   // Array contents survive reset so a host can inspect them after an abort.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Read ports see the pre-write contents on a same-cycle address collision.
   always_ff @(posedge clk) begin
      if (reset) begin
         core_rdata  <= '0;
         drain_rdata <= '0;
      end else begin
         core_rdata <= mem[core_raddr];
         if (drain_re) drain_rdata <= mem[drain_raddr];
      end
   end

endmodule

// File: rtl/sha256_mem_responder.sv
// Memory-side responder for the SHA-256 core: loads the message, runs the core, streams the hash back.
// Optional core address range checking is enabled by defining SHA_RESP_ADDR_CHECK_EN.
//
// state      | meaning
// IDLE       | waiting for the first message word
// LOAD       | accepting the remaining message words
// START      | one-cycle core_start pulse
// WAIT_LO    | waiting for core_done to drop (core has left idle)
// WAIT_HI    | waiting for core_done to rise (hash written)
// DRAIN_RD   | reading the next hash word from RAM
// DRAIN_PRES | presenting the hash word to the host
module sha256_mem_responder
   import sha_resp_pkg::*;
#(
   parameter int          NUM_OF_WORDS = 20,
   parameter int          DEPTH        = 64,
   parameter logic [15:0] MSG_BASE     = 16'h0000,
   parameter logic [15:0] OUT_BASE     = 16'h0020,
   parameter int          TIMEOUT_CYC  = 4096
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WORD_W-1:0] out_data,
   output logic              out_last,
   output logic              busy,
   output logic              err,
   output logic              core_start,
   input  logic              core_done,
   output logic [15:0]       message_addr,
   output logic [15:0]       output_addr,
   input  logic [15:0]       mem_addr,
   input  logic              mem_we,
   input  logic [WORD_W-1:0] mem_write_data,
   output logic [WORD_W-1:0] mem_read_data
);

   localparam int ADDR_W = $clog2(DEPTH);
   localparam int WCNT_W = $clog2(NUM_OF_WORDS);
   localparam int RCNT_W = $clog2(HASH_WORDS);
   localparam int TMR_W  = $clog2(TIMEOUT_CYC);

   resp_state_e       state, state_nxt;
   logic [WCNT_W-1:0] wcnt;
   logic [RCNT_W-1:0] rcnt;
   logic [TMR_W-1:0]  tmr;

   logic              host_we, core_we, ram_we, wait_st, timeout, addr_err, out_fire, wlast;
   logic [ADDR_W-1:0] host_addr, drain_addr, ram_waddr;
   logic [WORD_W-1:0] ram_wdata;
   logic              unused_addr_hi;

   assign message_addr = MSG_BASE;
   assign output_addr  = OUT_BASE;

   assign in_ready   = (state == ST_IDLE) || (state == ST_LOAD);
   assign busy       = (state != ST_IDLE);
   assign core_start = (state == ST_START);
   assign out_valid  = (state == ST_DRAIN_PRES);
   assign out_last   = out_valid && (rcnt == RCNT_W'(HASH_WORDS - 1));
   assign wait_st    = (state == ST_WAIT_LO) || (state == ST_WAIT_HI);
   assign timeout    = wait_st && (tmr == '0);
   assign host_we    = in_valid && in_ready;
   assign out_fire   = out_valid && out_ready;
   assign wlast      = (wcnt == WCNT_W'(NUM_OF_WORDS - 1));

   assign host_addr  = ADDR_W'(MSG_BASE) + ADDR_W'(wcnt);
   assign drain_addr = ADDR_W'(OUT_BASE) + ADDR_W'(rcnt);

   // Addresses wrap modulo DEPTH; the upper core address bits are deliberately ignored.
   assign unused_addr_hi = ^mem_addr[15:ADDR_W];

`ifdef SHA_RESP_ADDR_CHECK_EN
   logic [31:0] addr32;
   logic        in_msg, in_out;
   localparam logic [31:0] MSG_LO = {16'h0000, MSG_BASE};
   localparam logic [31:0] MSG_HI = MSG_LO + 32'(NUM_OF_WORDS);
   localparam logic [31:0] OUT_LO = {16'h0000, OUT_BASE};
   localparam logic [31:0] OUT_HI = OUT_LO + 32'(HASH_WORDS);

   assign addr32   = {16'h0000, mem_addr};
   assign in_msg   = (addr32 >= MSG_LO) && (addr32 < MSG_HI);
   assign in_out   = (addr32 >= OUT_LO) && (addr32 < OUT_HI);
   assign core_we  = wait_st && mem_we && in_out;
   assign addr_err = wait_st && (mem_we ? !in_out : !(in_msg || in_out));
`else
   assign core_we  = wait_st && mem_we;
   assign addr_err = 1'b0;
`endif

   // Host and core writes are state-exclusive, so the mux never has to arbitrate.
   assign ram_we    = host_we || core_we;
   assign ram_waddr = host_we ? host_addr : mem_addr[ADDR_W-1:0];
   assign ram_wdata = host_we ? in_data : mem_write_data;

   sha_resp_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
      .clk         (clk),
      .reset       (reset),
      .we          (ram_we),
      .waddr       (ram_waddr),
      .wdata       (ram_wdata),
      .core_raddr  (mem_addr[ADDR_W-1:0]),
      .core_rdata  (mem_read_data),
      .drain_re    (state == ST_DRAIN_RD),
      .drain_raddr (drain_addr),
      .drain_rdata (out_data)
   );

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE, ST_LOAD: if (host_we) state_nxt = wlast ? ST_START : ST_LOAD;
         ST_START:         state_nxt = ST_WAIT_LO;
         ST_WAIT_LO:       if (timeout) state_nxt = ST_IDLE;
                           else if (!core_done) state_nxt = ST_WAIT_HI;
         ST_WAIT_HI:       if (timeout) state_nxt = ST_IDLE;
                           else if (core_done) state_nxt = ST_DRAIN_RD;
         ST_DRAIN_RD:      state_nxt = ST_DRAIN_PRES;
         ST_DRAIN_PRES:    if (out_fire) state_nxt = out_last ? ST_IDLE : ST_DRAIN_RD;
         default:          state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
         wcnt  <= '0;
         rcnt  <= '0;
         tmr   <= '0;
         err   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (host_we) wcnt <= wlast ? '0 : wcnt + 1'b1;
         if (out_fire) rcnt <= rcnt + 1'b1;
         // Down-counter spans both WAIT states; terminal count aborts the job.
         if (state == ST_START) tmr <= TMR_W'(TIMEOUT_CYC - 1);
         else if (wait_st && !timeout) tmr <= tmr - 1'b1;
         if (host_we) err <= 1'b0;
         else if (timeout || addr_err) err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_sha256_mem_responder.sv
// Directed self-checking bench for sha256_mem_responder (honours SHA_RESP_ADDR_CHECK_EN).
module tb_sha256_mem_responder;

   localparam int TO = 4096;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_ready, out_valid, out_ready, out_last, busy, err;
   logic        core_start, core_done, mem_we;
   logic [31:0] in_data, out_data, mem_write_data, mem_read_data;
   logic [15:0] message_addr, output_addr, mem_addr;

   int n_run  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   sha256_mem_responder #(
      .NUM_OF_WORDS (20),
      .DEPTH        (64),
      .MSG_BASE     (16'h0000),
      .OUT_BASE     (16'h0020),
      .TIMEOUT_CYC  (TO)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_data        (in_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_data       (out_data),
      .out_last       (out_last),
      .busy           (busy),
      .err            (err),
      .core_start     (core_start),
      .core_done      (core_done),
      .message_addr   (message_addr),
      .output_addr    (output_addr),
      .mem_addr       (mem_addr),
      .mem_we         (mem_we),
      .mem_write_data (mem_write_data),
      .mem_read_data  (mem_read_data)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_run++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic load(input int base, input int n);
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1;
         in_data  = 32'(base + i);
         chk("in_ready_load", {31'b0, in_ready}, 32'd1);
         tick;
      end
      in_valid = 1'b0;
   endtask

   // Core model: drop done, write the 8 hash words, raise done.
   task automatic core_job(input int hbase);
      core_done = 1'b0;
      for (int k = 0; k < 8; k++) begin
         mem_we         = 1'b1;
         mem_addr       = 16'(16'h20 + k);
         mem_write_data = 32'(hbase + k);
         tick;
         chk("no_out_in_wait", {31'b0, out_valid}, 32'd0);
      end
      mem_we    = 1'b0;
      mem_addr  = 16'h0000;
      core_done = 1'b1;
      tick;
   endtask

   task automatic drain(input int hbase, input int stall_idx, input int stall_len);
      int idx   = 0;
      int stall = 0;
      int cyc   = 0;
      while (idx < 8 && cyc < 200) begin
         if (out_valid) begin
            chk("out_data", out_data, 32'(hbase + idx));
            chk("out_last", {31'b0, out_last}, {31'b0, idx == 7});
            if (idx == stall_idx && stall < stall_len) begin
               out_ready = 1'b0;
               stall++;
               tick;
               chk("stall_hold_valid", {31'b0, out_valid}, 32'd1);
            end else begin
               out_ready = 1'b1;
               idx++;
               tick;
            end
         end else begin
            out_ready = 1'b0;
            tick;
         end
         cyc++;
      end
      out_ready = 1'b0;
      chk("drain_count", 32'(idx), 32'd8);
      chk("busy_after_drain", {31'b0, busy}, 32'd0);
   endtask

   task automatic rd_check(input string tag, input logic [15:0] a, input logic [31:0] exp);
      mem_addr = a;
      tick;
      chk(tag, mem_read_data, exp);
   endtask

   initial begin
      int cnt;
      logic saw_valid;
      reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      core_done = 1'b1; mem_addr = '0; mem_we = 1'b0; mem_write_data = '0;
      tick; tick;
      chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_err", {31'b0, err}, 32'd0);
      chk("rst_core_start", {31'b0, core_start}, 32'd0);
      chk("rst_rdata", mem_read_data, 32'd0);
      chk("message_addr", {16'h0, message_addr}, 32'h0000);
      chk("output_addr", {16'h0, output_addr}, 32'h0020);
      reset = 1'b0;
      tick;

      // Job 1: load 0..19, start pulse, core read, hash A0..A7 streamed with out_ready held high
      load(0, 20);
      chk("start_pulse", {31'b0, core_start}, 32'd1);
      chk("in_ready_start", {31'b0, in_ready}, 32'd0);
      tick;
      chk("start_one_cycle", {31'b0, core_start}, 32'd0);
      chk("busy_wait", {31'b0, busy}, 32'd1);
      rd_check("core_rd_5", 16'd5, 32'd5);
      rd_check("core_rd_19", 16'd19, 32'd19);
      core_job(32'hA0);
      drain(32'hA0, 99, 0);

      // Job 2: stall out_ready for 5 cycles on word 2
      load(0, 20);
      tick;
      core_job(32'hA0);
      drain(32'hA0, 2, 5);

      // Core write outside the WAIT states is dropped
      mem_we = 1'b1; mem_addr = 16'h0020; mem_write_data = 32'h55;
      tick;
      mem_we = 1'b0;
      rd_check("idle_write_dropped", 16'h0020, 32'hA0);
      mem_addr = 16'h0000;

      // Job 3: core_done stuck high -> timeout
      load(0, 20);
      cnt = 0; saw_valid = 1'b0;
      while (!err && cnt < TO + 50) begin
         tick;
         cnt++;
         if (out_valid) saw_valid = 1'b1;
      end
      chk("timeout_err", {31'b0, err}, 32'd1);
      chk("timeout_window", {31'b0, (cnt >= TO) && (cnt <= TO + 2)}, 32'd1);
      chk("timeout_busy", {31'b0, busy}, 32'd0);
      chk("timeout_no_out", {31'b0, saw_valid}, 32'd0);

      // Partial load then reset: next job starts at MSG_BASE
      load(200, 7);
      chk("err_cleared_by_word", {31'b0, err}, 32'd0);
      chk("busy_loading", {31'b0, busy}, 32'd1);
      reset = 1'b1;
      tick;
      reset = 1'b0;
      chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
      chk("midrst_busy", {31'b0, busy}, 32'd0);
      tick;
      load(100, 20);
      tick;
      rd_check("reload_0", 16'd0, 32'd100);
      rd_check("reload_7", 16'd7, 32'd107);
      rd_check("reload_19", 16'd19, 32'd119);
      rd_check("wrap_addr_64", 16'd64, 32'd100);

      // WAIT-state core write to message word 5
      mem_we = 1'b1; mem_addr = 16'd5; mem_write_data = 32'hDEAD;
      tick;
      mem_we = 1'b0;
`ifdef SHA_RESP_ADDR_CHECK_EN
      rd_check("wait_wr5_blocked", 16'd5, 32'd105);
      chk("wait_wr5_err", {31'b0, err}, 32'd1);
`else
      rd_check("wait_wr5_done", 16'd5, 32'hDEAD);
      chk("wait_wr5_err", {31'b0, err}, 32'd0);
`endif
      mem_addr = 16'h0000;
      core_job(32'hC0);
      drain(32'hC0, 99, 0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
